// File: rtl/serial_cmp_pkg.sv
// Shared verdict encodings for the bit-serial comparator lanes.
package serial_cmp_pkg;

    typedef logic [1:0] cmp_state_t;

    localparam cmp_state_t SAME      = 2'b00;
    localparam cmp_state_t A_GREATER = 2'b01;
    localparam cmp_state_t B_GREATER = 2'b10;

endpackage

// File: rtl/serial_cmp_lane.sv
// One comparator lane: MSB-first verdict register plus selection of the
// larger/smaller operand bit for the current beat.
module serial_cmp_lane
    import serial_cmp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       ai,
    input  logic       bi,
    input  logic       accept,
    input  logic       first_bit,
    input  logic       sign_bit,
    input  logic       sel_min,
    output cmp_state_t state,
    output cmp_state_t next_state,
    output logic       out_bit
);

    cmp_state_t state_q;
    cmp_state_t state_d;
    cmp_state_t eval_from;
    cmp_state_t eval_state;

    always_comb begin
        // A frame's first beat ignores whatever verdict the previous frame left.
        eval_from  = first_bit ? SAME : state_q;
        eval_state = eval_from;
        if ((eval_from == SAME) && (ai != bi)) begin
            // On a two's-complement sign bit a set bit means the smaller value.
            if (ai ^ sign_bit) begin
                eval_state = A_GREATER;
            end else begin
                eval_state = B_GREATER;
            end
        end

        state_d = accept ? eval_state : state_q;

        case (eval_state)
            A_GREATER: out_bit = sel_min ? bi : ai;
            B_GREATER: out_bit = sel_min ? ai : bi;
            default:   out_bit = ai;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= SAME;
        end else begin
            state_q <= state_d;
        end
    end

    assign state      = state_q;
    assign next_state = state_d;

endmodule

// File: rtl/serial_cmp_sel.sv
// Multi-lane bit-serial MSB-first magnitude comparator/selector with framing,
// min/max selection, signed mode, per-frame verdicts and framing errors.
module serial_cmp_sel
    import serial_cmp_pkg::*;
#(
    parameter int N_LANES = 4,
    parameter int W       = 8,
    parameter int SIGNED  = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   sof,
    input  logic                   mode_min,
    input  logic [N_LANES-1:0]     ai,
    input  logic [N_LANES-1:0]     bi,
    output logic [N_LANES-1:0]     out,
    output logic                   out_valid,
    output logic                   done,
    output logic [2*N_LANES-1:0]   result,
    output logic                   frame_err,
    output logic [2*N_LANES-1:0]   dbg_state
);

    localparam int             CW       = $clog2(W);
    localparam logic [CW-1:0]  LAST_IDX = CW'(W - 1);

    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   active_q, active_d;
    logic                   mode_q, mode_d;
    logic [N_LANES-1:0]     out_q, out_d;
    logic                   out_valid_q, out_valid_d;
    logic                   done_q, done_d;
    logic [2*N_LANES-1:0]   result_q, result_d;
    logic                   frame_err_q, frame_err_d;

    logic                   sof_beat;
    logic                   accept;
    logic [CW-1:0]          bit_idx;
    logic                   last_beat;
    logic                   sel_min;
    logic                   sign_bit;
    logic [N_LANES-1:0]     lane_out;
    logic [2*N_LANES-1:0]   lane_next;
    logic [2*N_LANES-1:0]   lane_state;

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        serial_cmp_lane u_lane (
            .clk        (clk),
            .reset      (reset),
            .ai         (ai[k]),
            .bi         (bi[k]),
            .accept     (accept),
            .first_bit  (sof_beat),
            .sign_bit   (sign_bit),
            .sel_min    (sel_min),
            .state      (lane_state[2*k +: 2]),
            .next_state (lane_next[2*k +: 2]),
            .out_bit    (lane_out[k])
        );
    end

    always_comb begin
        sof_beat  = in_valid & sof;
        accept    = in_valid & (sof | active_q);
        bit_idx   = sof ? '0 : cnt_q;
        last_beat = accept && (bit_idx == LAST_IDX);
        // The sof beat already obeys the mode it carries.
        sel_min   = sof_beat ? mode_min : mode_q;
        sign_bit  = (SIGNED != 0) && (bit_idx == '0);

        cnt_d    = cnt_q;
        active_d = active_q;
        mode_d   = mode_q;
        if (sof_beat) begin
            mode_d = mode_min;
        end
        if (accept) begin
            cnt_d    = last_beat ? '0 : bit_idx + CW'(1);
            active_d = !last_beat;
        end

        out_valid_d = accept;
        out_d       = accept ? lane_out : out_q;
        done_d      = last_beat;
        result_d    = last_beat ? lane_next : result_q;
        // Active implies a nonzero index, so sof here always aborts a frame.
        frame_err_d = in_valid & ((sof & active_q) | (~sof & ~active_q));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q       <= '0;
            active_q    <= 1'b0;
            mode_q      <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            mode_q      <= mode_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            result_q    <= result_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign result    = result_q;
    assign frame_err = frame_err_q;
    assign dbg_state = lane_state;

endmodule

// File: tb/tb_serial_cmp_sel.sv
// Bench for serial_cmp_sel: unsigned and signed instances share one stimulus
// stream; expectations come from whole-operand arithmetic per frame.
module tb_serial_cmp_sel;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           in_valid = 1'b0;
    logic           sof = 1'b0;
    logic           mode_min = 1'b0;
    logic [N-1:0]   ai = '0;
    logic [N-1:0]   bi = '0;

    logic [N-1:0]   out_u, out_s;
    logic           ov_u, ov_s, done_u, done_s, err_u, err_s;
    logic [2*N-1:0] res_u, res_s, dbg_u, dbg_s;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_res_u = '0;
    logic [7:0] exp_res_s = '0;
    bit pending_abort = 1'b0;

    always #5 clk = ~clk;

    serial_cmp_sel #(.N_LANES(N), .W(W), .SIGNED(0)) u_dut_u (
        .clk(clk), .reset(reset), .in_valid(in_valid), .sof(sof), .mode_min(mode_min),
        .ai(ai), .bi(bi), .out(out_u), .out_valid(ov_u), .done(done_u),
        .result(res_u), .frame_err(err_u), .dbg_state(dbg_u)
    );

    serial_cmp_sel #(.N_LANES(N), .W(W), .SIGNED(1)) u_dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .sof(sof), .mode_min(mode_min),
        .ai(ai), .bi(bi), .out(out_s), .out_valid(ov_s), .done(done_s),
        .result(res_s), .frame_err(err_s), .dbg_state(dbg_s)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          m;
        int          gap;
        logic [31:0] su;
        logic [31:0] ss;
        logic [7:0]  ru;
        logic [7:0]  rs;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input bit s, input bit m,
                         input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        in_valid = v; sof = s; mode_min = m; ai = a; bi = b;
        @(posedge clk);
        #1;
    endtask

    // Verdict and selected operand per lane from the integer values of a and b.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input bit m,
                         input bit sgn, output logic [31:0] sel, output logic [7:0] res);
        sel = '0;
        res = '0;
        for (int k = 0; k < N; k++) begin
            logic [7:0] x, y;
            int va, vb;
            bit take_b;
            x = a[8*k +: 8];
            y = b[8*k +: 8];
            va = sgn ? int'($signed(x)) : int'(x);
            vb = sgn ? int'($signed(y)) : int'(y);
            if (va > vb)      res[2*k +: 2] = 2'b01;
            else if (va < vb) res[2*k +: 2] = 2'b10;
            else              res[2*k +: 2] = 2'b00;
            take_b = m ? (va > vb) : (va < vb);
            sel[8*k +: 8] = take_b ? y : x;
        end
    endtask

    task automatic run_frame_exp(input logic [31:0] a, input logic [31:0] b, input bit m,
                                 input int gap_mode, input int nb,
                                 input logic [31:0] su, input logic [31:0] ss,
                                 input logic [7:0] ru, input logic [7:0] rs);
        logic [3:0] av, bv, eu, es;
        bit last, e;
        for (int i = 0; i < nb; i++) begin
            int idles;
            idles = 0;
            if (gap_mode == 1 && (i % 2) == 1) idles = 2;
            else if (gap_mode == 2) idles = $urandom_range(0, 2);
            for (int g = 0; g < idles; g++) begin
                drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      4'($urandom), 4'($urandom));
                chk("idle_out_valid", {ov_s, ov_u}, 0);
                chk("idle_done", {done_s, done_u}, 0);
                chk("idle_frame_err", {err_s, err_u}, 0);
                chk("idle_result", {res_s, res_u}, {exp_res_s, exp_res_u});
            end
            for (int k = 0; k < N; k++) begin
                av[k] = a[8*k + W-1-i];
                bv[k] = b[8*k + W-1-i];
                eu[k] = su[8*k + W-1-i];
                es[k] = ss[8*k + W-1-i];
            end
            e = (i == 0) && pending_abort;
            drive(1'b1, i == 0, (i == 0) ? m : 1'($urandom_range(0, 1)), av, bv);
            last = (i == W-1);
            if (last) begin
                exp_res_u = ru;
                exp_res_s = rs;
            end
            chk("beat_out_valid", {ov_s, ov_u}, 2'b11);
            chk("out_unsigned", out_u, eu);
            chk("out_signed", out_s, es);
            chk("done", {done_s, done_u}, {last, last});
            chk("frame_err", {err_s, err_u}, {e, e});
            chk("result", {res_s, res_u}, {exp_res_s, exp_res_u});
            if (last) chk("dbg_state", {dbg_s, dbg_u}, {rs, ru});
        end
        pending_abort = (nb > 0) && (nb < W);
    endtask

    task automatic run_model_frame(input logic [31:0] a, input logic [31:0] b, input bit m,
                                   input int gap_mode, input int nb);
        logic [31:0] su, ss;
        logic [7:0] ru, rs;
        model(a, b, m, 1'b0, su, ru);
        model(a, b, m, 1'b1, ss, rs);
        run_frame_exp(a, b, m, gap_mode, nb, su, ss, ru, rs);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out"}, {out_s, out_u}, 0);
        chk({tag, "_out_valid"}, {ov_s, ov_u}, 0);
        chk({tag, "_done"}, {done_s, done_u}, 0);
        chk({tag, "_result"}, {res_s, res_u}, 0);
        chk({tag, "_frame_err"}, {err_s, err_u}, 0);
        chk({tag, "_dbg"}, {dbg_s, dbg_u}, 0);
    endtask

    initial begin
        vec_t vecs[4];
        // lanes: {lane3, lane2, lane1, lane0}
        vecs[0] = '{a: 32'hFF803C5A, b: 32'hFE01C35A, m: 1'b0, gap: 0,
                    su: 32'hFF80C35A, ss: 32'hFF013C5A, ru: 8'h58, rs: 8'h64};
        vecs[1] = '{a: 32'hFF803C5A, b: 32'hFE01C35A, m: 1'b1, gap: 0,
                    su: 32'hFE013C5A, ss: 32'hFE80C35A, ru: 8'h58, rs: 8'h64};
        vecs[2] = '{a: 32'h00000000, b: 32'hFFFFFFFF, m: 1'b0, gap: 0,
                    su: 32'hFFFFFFFF, ss: 32'h00000000, ru: 8'hAA, rs: 8'h55};
        vecs[3] = '{a: 32'h7F7F7F7F, b: 32'h80808080, m: 1'b1, gap: 1,
                    su: 32'h7F7F7F7F, ss: 32'h80808080, ru: 8'hAA, rs: 8'h55};

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < 4; v++) begin
            run_frame_exp(vecs[v].a, vecs[v].b, vecs[v].m, vecs[v].gap, W,
                          vecs[v].su, vecs[v].ss, vecs[v].ru, vecs[v].rs);
        end

        // Beat with no active frame is dropped and flagged.
        drive(1'b1, 1'b0, 1'b0, 4'hF, 4'h0);
        chk("orphan_out_valid", {ov_s, ov_u}, 0);
        chk("orphan_frame_err", {err_s, err_u}, 2'b11);
        chk("orphan_done", {done_s, done_u}, 0);
        chk("orphan_result", {res_s, res_u}, {exp_res_s, exp_res_u});

        // sof after 4 beats aborts the frame; the new frame completes.
        run_model_frame(32'h12345678, 32'h87654321, 1'b0, 0, 4);
        run_frame_exp(vecs[1].a, vecs[1].b, vecs[1].m, 0, W,
                      vecs[1].su, vecs[1].ss, vecs[1].ru, vecs[1].rs);

        // Reset at beat 5 discards the frame and clears the result.
        run_model_frame(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 0, 5);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b1; sof = 1'b0; ai = 4'($urandom); bi = 4'($urandom);
        @(posedge clk);
        #1;
        chk_all_zero("midframe_reset");
        exp_res_u = '0;
        exp_res_s = '0;
        pending_abort = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        run_frame_exp(vecs[0].a, vecs[0].b, vecs[0].m, 0, W,
                      vecs[0].su, vecs[0].ss, vecs[0].ru, vecs[0].rs);

        for (int r = 0; r < 40; r++) begin
            int nb;
            nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, W-1) : W;
            run_model_frame($urandom, $urandom, 1'($urandom_range(0, 1)), 2, nb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
